mem_port_arbiter: RTL

// Shares one single-port synchronous memory between the core's instruction-fetch
// bus and data bus. The core keeps separate ibus/dbus request ports.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and data buses.
// Data has priority; a streak counter forces a fetch grant after MAX_DSTREAK data wins.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int LATENCY     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STRK_W = (MAX_DSTREAK > 1) ? $clog2(MAX_DSTREAK + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STRK_W-1:0]   dstreak_q;
  logic [STRK_W-1:0]   dstreak_d;
  logic                grant_data_d;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic                busy_q;
  logic                owner_q;

  // Data wins any contention unless it has already won MAX_DSTREAK times in a row.
  always_comb begin
    grant_data_d = d_req && !(i_req && (dstreak_q == STRK_W'(MAX_DSTREAK)));
    dstreak_d    = '0;
    if (i_req) begin
      dstreak_d = (dstreak_q == STRK_W'(MAX_DSTREAK)) ? dstreak_q : dstreak_q + STRK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dstreak_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            state_q  <= ISSUE;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            owner_q  <= grant_data_d;
            if (grant_data_d) begin
              mem_addr_q  <= d_addr;
              mem_we_q    <= d_we;
              mem_wdata_q <= d_wdata;
              dstreak_q   <= dstreak_d;
            end else begin
              // Fetches are read-only; write data register is left untouched.
              mem_addr_q <= i_addr;
              mem_we_q   <= 1'b0;
              dstreak_q  <= '0;
            end
          end
        end
        ISSUE: begin
          cnt_q <= CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_q <= ACK;
            i_ack_q <= !owner_q;
            d_ack_q <= owner_q;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ACK;
            i_ack_q <= !owner_q;
            d_ack_q <= owner_q;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule
